cplx_seq_datapath: RTL and testbench

Parametrised, programmable successor to the 8-bit complex ALU datapath. It runs a stored program of complex-arithmetic instructions over a stream of operand pairs and writes each result into an addressable result file. Results can be read back and are also emitted on a valid-qualified output. A start/busy/done handshake lets a host sequencer launch runs and wait for them to finish.

---
 rtl/cplx_seq_datapath.sv | 254 +++++++++++++++++++++++++
 tb/tb_cplx_seq_datapath.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cplx_seq_datapath.sv
// Programmable complex-arithmetic sequencer: runs a stored program over an
// operand stream and writes each result to a small addressable result file.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start / busy / done     run launch handshake
//   prog_we/addr/data       program load port, instruction = {op, dst}
//   in_valid / in_ready     operand pair handshake (a_re, a_im, b_re, b_im)
//   out_valid/addr/re/im    result write pulse and value
//   rd_addr / rd_re / rd_im combinational result-file read
//
// Build option: CPLX_SAT_EN selects saturating reduction (default wraps).
module cplx_seq_datapath #(
    parameter  int DW         = 8,
    parameter  int PROG_DEPTH = 16,
    parameter  int RES_DEPTH  = 8,
    localparam int PA         = $clog2(PROG_DEPTH),
    localparam int RA         = $clog2(RES_DEPTH),
    localparam int IW         = 3 + RA
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          prog_we,
    input  logic [PA-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a_re,
    input  logic [DW-1:0] a_im,
    input  logic [DW-1:0] b_re,
    input  logic [DW-1:0] b_im,
    output logic          out_valid,
    output logic [RA-1:0] out_addr,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    input  logic [RA-1:0] rd_addr,
    output logic [DW-1:0] rd_re,
    output logic [DW-1:0] rd_im
);

    // Exact results (products and sums of products) fit in 2*DW+1 bits.
    localparam int W = 2 * DW + 1;
    localparam logic [PA-1:0] PC_LAST = PA'(PROG_DEPTH - 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_CONJ = 3'b011;
    localparam logic [2:0] OP_MAG2 = 3'b100;
    localparam logic [2:0] OP_NOP0 = 3'b101;
    localparam logic [2:0] OP_NOP1 = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_OP,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PA-1:0] pc_q, pc_d;
    logic [IW-1:0] ins_q, ins_d;
    logic [DW-1:0] a_re_q, a_re_d, a_im_q, a_im_d;
    logic [DW-1:0] b_re_q, b_re_d, b_im_q, b_im_d;
    logic [DW-1:0] r_re_q, r_re_d, r_im_q, r_im_d;

    logic [IW-1:0] prog_q   [PROG_DEPTH];
    logic [DW-1:0] res_re_q [RES_DEPTH];
    logic [DW-1:0] res_im_q [RES_DEPTH];

    logic          prog_wr;
    logic          res_wr;
    logic [IW-1:0] fetch_ins;
    logic [2:0]    fetch_op;
    logic [2:0]    op;
    logic [RA-1:0] dst;

    logic signed [W-1:0] xa_re, xa_im, xb_re, xb_im;
    logic signed [W-1:0] v_re, v_im;

    function automatic logic signed [W-1:0] sext(input logic [DW-1:0] x);
        return {{(W - DW){x[DW-1]}}, x};
    endfunction

`ifdef CPLX_SAT_EN
    localparam logic signed [W-1:0] SMAX = W'((1 << (DW - 1)) - 1);
    localparam logic signed [W-1:0] SMIN = ~SMAX;

    function automatic logic [DW-1:0] reduce(input logic signed [W-1:0] v);
        if (v > SMAX) return SMAX[DW-1:0];
        if (v < SMIN) return SMIN[DW-1:0];
        return v[DW-1:0];
    endfunction
`else
    function automatic logic [DW-1:0] reduce(input logic signed [W-1:0] v);
        return v[DW-1:0];
    endfunction
`endif

    assign fetch_ins = prog_q[pc_q];
    assign fetch_op  = fetch_ins[IW-1:RA];
    assign op        = ins_q[IW-1:RA];
    assign dst       = ins_q[RA-1:0];

    // Datapath: full-precision result, shifted for the Q1.(DW-1) ops.
    always_comb begin
        xa_re = sext(a_re_q);
        xa_im = sext(a_im_q);
        xb_re = sext(b_re_q);
        xb_im = sext(b_im_q);
        v_re  = '0;
        v_im  = '0;
        case (op)
            OP_ADD: begin
                v_re = xa_re + xb_re;
                v_im = xa_im + xb_im;
            end
            OP_SUB: begin
                v_re = xa_re - xb_re;
                v_im = xa_im - xb_im;
            end
            OP_MUL: begin
                v_re = (xa_re * xb_re - xa_im * xb_im) >>> (DW - 1);
                v_im = (xa_re * xb_im + xa_im * xb_re) >>> (DW - 1);
            end
            OP_CONJ: begin
                v_re = xa_re;
                v_im = -xa_im;
            end
            OP_MAG2: begin
                v_re = (xa_re * xa_re + xa_im * xa_im) >>> (DW - 1);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        a_re_d  = a_re_q;
        a_im_d  = a_im_q;
        b_re_d  = b_re_q;
        b_im_d  = b_im_q;
        r_re_d  = r_re_q;
        r_im_d  = r_im_q;
        prog_wr = 1'b0;
        res_wr  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                prog_wr = prog_we;
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ins_d = fetch_ins;
                if (fetch_op == OP_HALT) begin
                    state_d = S_DONE;
                end else if (fetch_op == OP_NOP0 || fetch_op == OP_NOP1) begin
                    // pc saturates at the last slot instead of wrapping
                    if (pc_q == PC_LAST) state_d = S_DONE;
                    else pc_d = pc_q + PA'(1);
                end else begin
                    state_d = S_WAIT_OP;
                end
            end
            S_WAIT_OP: begin
                if (in_valid) begin
                    a_re_d  = a_re;
                    a_im_d  = a_im;
                    b_re_d  = b_re;
                    b_im_d  = b_im;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                r_re_d  = reduce(v_re);
                r_im_d  = reduce(v_im);
                state_d = S_WRITE;
            end
            S_WRITE: begin
                res_wr = 1'b1;
                if (pc_q == PC_LAST) begin
                    state_d = S_DONE;
                end else begin
                    pc_d    = pc_q + PA'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ins_q   <= '0;
            a_re_q  <= '0;
            a_im_q  <= '0;
            b_re_q  <= '0;
            b_im_q  <= '0;
            r_re_q  <= '0;
            r_im_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            a_re_q  <= a_re_d;
            a_im_q  <= a_im_d;
            b_re_q  <= b_re_d;
            b_im_q  <= b_im_d;
            r_re_q  <= r_re_d;
            r_im_q  <= r_im_d;
        end
    end

    // Program slots reset to HALT so an unloaded program ends immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PROG_DEPTH; i++) prog_q[i] <= '1;
            for (int i = 0; i < RES_DEPTH; i++) begin
                res_re_q[i] <= '0;
                res_im_q[i] <= '0;
            end
        end else begin
            if (prog_wr) prog_q[prog_addr] <= prog_data;
            if (res_wr) begin
                res_re_q[dst] <= r_re_q;
                res_im_q[dst] <= r_im_q;
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign in_ready  = (state_q == S_WAIT_OP);
    assign out_valid = (state_q == S_WRITE);
    assign out_addr  = dst;
    assign out_re    = r_re_q;
    assign out_im    = r_im_q;
    assign rd_re     = res_re_q[rd_addr];
    assign rd_im     = res_im_q[rd_addr];

endmodule

// File: tb/tb_cplx_seq_datapath.sv
// Self-checking bench for cplx_seq_datapath: table vectors, hand sequences
// for handshake/reset/full-program cases, and randomized programs.
module tb_cplx_seq_datapath;

    localparam int DW = 8;
    localparam int PA = 4;
    localparam int RA = 3;
    localparam int IW = 6;
`ifdef CPLX_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          prog_we = 1'b0;
    logic [PA-1:0] prog_addr = '0;
    logic [IW-1:0] prog_data = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic [RA-1:0] rd_addr = '0;
    logic          busy, done, in_ready, out_valid;
    logic [RA-1:0] out_addr;
    logic [DW-1:0] out_re, out_im, rd_re, rd_im;

    cplx_seq_datapath dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid), .out_addr(out_addr),
        .out_re(out_re), .out_im(out_im),
        .rd_addr(rd_addr), .rd_re(rd_re), .rd_im(rd_im)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [7:0] ar, ai, br, bi;} opnd_t;
    typedef struct packed {logic [2:0] addr; logic [7:0] re, im;} res_t;
    typedef struct {
        logic [2:0] op, dst;
        logic [7:0] ar, ai, br, bi, er, ei;
    } vec_t;

    opnd_t      opq[$];
    res_t       expq[$];
    logic [7:0] mre[8];
    logic [7:0] mim[8];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Reference: plain integer arithmetic, floor division, then reduce.
    function automatic logic [7:0] red(input int v);
`ifdef CPLX_SAT_EN
        if (v > 127) return 8'h7f;
        if (v < -128) return 8'h80;
`endif
        return v[7:0];
    endfunction

    function automatic int fdiv(input int v);
        int q = v / 128;
        if ((v % 128) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [15:0] model(input logic [2:0] op,
                                          input logic [7:0] ar, ai, br, bi);
        int xr, xi, yr, yi, vr, vi;
        xr = int'($signed(ar));
        xi = int'($signed(ai));
        yr = int'($signed(br));
        yi = int'($signed(bi));
        vr = 0;
        vi = 0;
        case (op)
            3'd0: begin vr = xr + yr; vi = xi + yi; end
            3'd1: begin vr = xr - yr; vi = xi - yi; end
            3'd2: begin vr = fdiv(xr * yr - xi * yi); vi = fdiv(xr * yi + xi * yr); end
            3'd3: begin vr = xr; vi = -xi; end
            3'd4: vr = fdiv(xr * xr + xi * xi);
            default: ;
        endcase
        return {red(vr), red(vi)};
    endfunction

    task automatic push(input logic [2:0] dst, input logic [7:0] ar, ai, br, bi,
                        input logic [15:0] e);
        opq.push_back('{ar, ai, br, bi});
        expq.push_back('{dst, e[15:8], e[7:0]});
        mre[dst] = e[15:8];
        mim[dst] = e[7:0];
    endtask

    task automatic load(input int slot, input logic [2:0] op, input logic [2:0] dst);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = PA'(slot);
        prog_data = {op, dst};
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic check_rf(input string nm);
        for (int a = 0; a < 8; a++) begin
            rd_addr = RA'(a);
            #1;
            chk(nm, {rd_re, rd_im}, {mre[a], mim[a]});
        end
    endtask

    // Launch a run, feed queued operands, check each out_valid pulse.
    task automatic run(input bit poke);
        int cyc = 0;
        bit fin = 0;
        res_t e;
        opnd_t o;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 400) begin
            if (out_valid) begin
                if (expq.size() == 0) fail_now("extra_out_valid");
                else begin
                    e = expq.pop_front();
                    chk("out_addr", {13'd0, out_addr}, {13'd0, e.addr});
                    chk("out_val", {out_re, out_im}, {e.re, e.im});
                end
            end
            if (done) fin = 1;
            in_valid = 1'b0;
            if (!fin && in_ready && opq.size() > 0) begin
                o = opq.pop_front();
                {a_re, a_im, b_re, b_im} = o;
                in_valid = 1'b1;
            end
            start   = poke && cyc == 5;
            prog_we = poke && cyc == 5;
            prog_addr = 4'd3;
            prog_data = 6'h3f;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        prog_we = 1'b0;
        if (!fin) fail_now("run_timeout");
        chk("results_left", 16'(expq.size()), 16'd0);
        expq.delete();
        opq.delete();
    endtask

    initial begin
        vec_t tbl[11];
        logic [15:0] e;
        int n;
        tbl[0]  = '{3'd0, 3'd1, 8'h03, 8'h04, 8'h01, 8'hfe, 8'h04, 8'h02};
        tbl[1]  = '{3'd1, 3'd2, 8'h03, 8'h04, 8'h01, 8'hfe, 8'h02, 8'h06};
        tbl[2]  = '{3'd2, 3'd3, 8'h40, 8'h00, 8'h40, 8'h40, 8'h20, 8'h20};
        tbl[3]  = '{3'd2, 3'd4, 8'h80, 8'h00, 8'h80, 8'h00, SAT ? 8'h7f : 8'h80, 8'h00};
        tbl[4]  = '{3'd0, 3'd5, 8'h64, 8'h00, 8'h64, 8'h00, SAT ? 8'h7f : 8'hc8, 8'h00};
        tbl[5]  = '{3'd3, 3'd6, 8'h05, 8'hf9, 8'h00, 8'h00, 8'h05, 8'h07};
        tbl[6]  = '{3'd3, 3'd7, 8'h80, 8'h80, 8'h00, 8'h00, 8'h80, SAT ? 8'h7f : 8'h80};
        tbl[7]  = '{3'd4, 3'd0, 8'h40, 8'h40, 8'h00, 8'h00, 8'h40, 8'h00};
        tbl[8]  = '{3'd1, 3'd1, 8'h80, 8'h00, 8'h01, 8'h00, SAT ? 8'h80 : 8'h7f, 8'h00};
        tbl[9]  = '{3'd2, 3'd2, 8'hff, 8'h00, 8'h01, 8'h00, 8'hff, 8'h00};
        tbl[10] = '{3'd4, 3'd3, 8'h80, 8'h80, 8'h00, 8'h00, SAT ? 8'h7f : 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) begin
            mre[i] = 8'h00;
            mim[i] = 8'h00;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ctl", {12'd0, busy, done, in_ready, out_valid}, 16'd0);
        chk("rst_out", {out_re, out_im}, 16'd0);
        chk("rst_addr", {13'd0, out_addr}, 16'd0);
        check_rf("rst_rf");
        rst_n = 1'b1;

        // ADD/SUB program with two operand pairs
        load(0, 3'd0, 3'd1);
        load(1, 3'd1, 3'd2);
        load(2, 3'd7, 3'd0);
        push(3'd1, 8'h03, 8'h04, 8'h01, 8'hfe, 16'h0402);
        push(3'd2, 8'h03, 8'h04, 8'h01, 8'hfe, 16'h0206);
        run(1'b0);
        check_rf("addsub_rf");

        // Table vectors, one instruction per run
        load(1, 3'd7, 3'd0);
        for (int i = 0; i < 11; i++) begin
            load(0, tbl[i].op, tbl[i].dst);
            push(tbl[i].dst, tbl[i].ar, tbl[i].ai, tbl[i].br, tbl[i].bi,
                 {tbl[i].er, tbl[i].ei});
            run(1'b0);
        end
        check_rf("tbl_rf");

        // NOPs consume no operands and do not write
        load(0, 3'd5, 3'd0);
        load(1, 3'd6, 3'd1);
        load(2, 3'd0, 3'd4);
        load(3, 3'd7, 3'd0);
        push(3'd4, 8'h11, 8'h22, 8'h01, 8'h02, 16'h1224);
        run(1'b0);

        // Stall in WAIT_OP, then handshake and check write timing
        load(0, 3'd0, 3'd5);
        load(1, 3'd7, 3'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("stall_no_ready");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_ctl", {12'd0, busy, done, in_ready, out_valid}, 16'b1010);
        end
        rd_addr = 3'd5;
        {a_re, a_im, b_re, b_im} = {8'd10, 8'd20, 8'd1, 8'd1};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("hs_exec_ctl", {12'd0, busy, done, in_ready, out_valid}, 16'b1000);
        @(negedge clk);
        chk("hs_valid", {15'd0, out_valid}, 16'd1);
        chk("hs_addr", {13'd0, out_addr}, 16'd5);
        chk("hs_val", {out_re, out_im}, 16'h0b15);
        chk("rd_old", {rd_re, rd_im}, {mre[5], mim[5]});
        mre[5] = 8'h0b;
        mim[5] = 8'h15;
        @(negedge clk);
        chk("rd_new", {rd_re, rd_im}, 16'h0b15);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) fail_now("stall_no_done");

        // Full 16-slot program, no HALT; mid-run start/prog_we ignored
        for (int i = 0; i < 16; i++) begin
            load(i, 3'd0, 3'(i % 8));
            e = model(3'd0, 8'(i + 1), 8'(i), 8'd1, 8'd2);
            push(3'(i % 8), 8'(i + 1), 8'(i), 8'd1, 8'd2, e);
        end
        run(1'b1);
        check_rf("full_rf");

        // Randomized four-instruction programs
        load(4, 3'd7, 3'd0);
        for (int r = 0; r < 12; r++) begin
            for (int s = 0; s < 4; s++) begin
                logic [2:0] op, dst;
                logic [7:0] ar, ai, br, bi;
                op  = 3'($urandom_range(0, 4));
                dst = 3'($urandom_range(0, 7));
                ar = 8'($urandom);
                ai = 8'($urandom);
                br = 8'($urandom);
                bi = 8'($urandom);
                load(s, op, dst);
                push(dst, ar, ai, br, bi, model(op, ar, ai, br, bi));
            end
            run(1'b0);
        end
        check_rf("rand_rf");

        // Reset asserted during EXEC
        load(0, 3'd2, 3'd1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        {a_re, a_im, b_re, b_im} = {8'h40, 8'h40, 8'h40, 8'h40};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_ctl", {12'd0, busy, done, in_ready, out_valid}, 16'd0);
        chk("arst_out", {out_re, out_im}, 16'd0);
        chk("arst_addr", {13'd0, out_addr}, 16'd0);
        for (int i = 0; i < 8; i++) begin
            mre[i] = 8'h00;
            mim[i] = 8'h00;
        end
        check_rf("arst_rf");
        @(negedge clk);
        chk("arst_hold", {12'd0, busy, done, in_ready, out_valid}, 16'd0);
        rst_n = 1'b1;

        // Fresh run hits the reset HALT at pc=0; back-to-back start
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("halt_c1", {12'd0, busy, done, in_ready, out_valid}, 16'b1000);
        @(negedge clk);
        chk("halt_c2", {12'd0, busy, done, in_ready, out_valid}, 16'b1100);
        @(negedge clk);
        chk("halt_idle", {12'd0, busy, done, in_ready, out_valid}, 16'b0000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {12'd0, busy, done, in_ready, out_valid}, 16'b1000);
        @(negedge clk);
        chk("b2b_done", {12'd0, busy, done, in_ready, out_valid}, 16'b1100);
        @(negedge clk);
        check_rf("end_rf");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
